// File: rtl/fp32_pkg.sv
// Shared binary32 types, constants and helpers for the FP datapath.
package fp32_pkg;

    localparam int unsigned  EXP_BIAS = 127;
    localparam logic [7:0]   EXP_MAX  = 8'hFF;
    localparam logic [31:0]  QNAN     = 32'h7FC00000;
    localparam int unsigned  FRAC_W   = 23;
    localparam int unsigned  MANT_W   = 24;

    typedef struct packed {
        logic             sign;
        logic [7:0]       exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NORMAL = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } fp_class_e;

    function automatic logic [31:0] pack_fp(input logic sign, input logic [7:0] exp,
                                            input logic [FRAC_W-1:0] frac);
        return {sign, exp, frac};
    endfunction

endpackage

// File: rtl/fp32_classify.sv
// Operand classifier; subnormals are treated as zero (flush-to-zero).
module fp32_classify
    import fp32_pkg::*;
(
    input  logic [31:0] op_i,
    output fp_class_e   class_o
);

    fp32_t op_s;
    assign op_s = op_i;

    // Decode exponent/fraction into the operand class
    always_comb begin
        class_o = NORMAL;
        if (op_s.exp == 8'h00) begin
            class_o = ZERO;
        end else if (op_s.exp == EXP_MAX) begin
            if (op_s.frac == 23'd0) begin
                class_o = INF;
            end else begin
                class_o = NAN;
            end
        end else begin
            class_o = NORMAL;
        end
    end

endmodule

// File: rtl/fp32_mult.sv
// binary32 multiplier, round-to-nearest-even, flush-to-zero, one registered stage.
module fp32_mult
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);

    fp32_t            a_s, b_s;
    fp_class_e        cls_a_s, cls_b_s;
    logic             sign_s;
    logic [47:0]      mant_a_s, mant_b_s, prod_s;
    logic signed [9:0] exp_raw_s, exp_norm_s, exp_fin_s;
    logic [22:0]      frac_s;
    logic             guard_s, sticky_s, round_up_s;
    logic [23:0]      mant_rnd_s;
    logic [31:0]      result_d, result_q;
    logic             overflow_d, overflow_q, underflow_d, underflow_q;

    assign a_s = A;
    assign b_s = B;

    fp32_classify u_cls_a (.op_i(A), .class_o(cls_a_s));
    fp32_classify u_cls_b (.op_i(B), .class_o(cls_b_s));

    // Multiply, normalize, round and pack, then resolve specials and range
    always_comb begin
        sign_s     = a_s.sign ^ b_s.sign;
        mant_a_s   = {24'd0, 1'b1, a_s.frac};
        mant_b_s   = {24'd0, 1'b1, b_s.frac};
        prod_s     = mant_a_s * mant_b_s;
        exp_raw_s  = $signed({2'b00, a_s.exp}) + $signed({2'b00, b_s.exp})
                   - $signed(10'(EXP_BIAS));
        if (prod_s[47]) begin
            frac_s     = prod_s[46:24];
            guard_s    = prod_s[23];
            sticky_s   = |prod_s[22:0];
            exp_norm_s = exp_raw_s + 10'sd1;
        end else begin
            frac_s     = prod_s[45:23];
            guard_s    = prod_s[22];
            sticky_s   = |prod_s[21:0];
            exp_norm_s = exp_raw_s;
        end
        round_up_s = guard_s & (sticky_s | frac_s[0]);
        mant_rnd_s = {1'b0, frac_s} + {23'd0, round_up_s};
        // A carry out leaves the low 23 bits at zero, i.e. mantissa 1.0
        if (mant_rnd_s[23]) begin
            exp_fin_s = exp_norm_s + 10'sd1;
        end else begin
            exp_fin_s = exp_norm_s;
        end

        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if ((cls_a_s == NAN) || (cls_b_s == NAN)) begin
            result_d = QNAN;
        end else if (((cls_a_s == INF) && (cls_b_s == ZERO)) ||
                     ((cls_a_s == ZERO) && (cls_b_s == INF))) begin
            result_d = QNAN;
        end else if ((cls_a_s == INF) || (cls_b_s == INF)) begin
            result_d = pack_fp(sign_s, EXP_MAX, 23'd0);
        end else if ((cls_a_s == ZERO) || (cls_b_s == ZERO)) begin
            result_d = pack_fp(sign_s, 8'h00, 23'd0);
        end else if (exp_fin_s >= 10'sd255) begin
            result_d   = pack_fp(sign_s, EXP_MAX, 23'd0);
            overflow_d = 1'b1;
        end else if (exp_fin_s <= 10'sd0) begin
            result_d    = pack_fp(sign_s, 8'h00, 23'd0);
            underflow_d = 1'b1;
        end else begin
            result_d = pack_fp(sign_s, exp_fin_s[7:0], mant_rnd_s[22:0]);
        end
    end

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= 32'h0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign result    = result_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fp32_mult.sv
// Self-checking bench for fp32_mult: directed cases, reset behaviour and random vectors vs an arithmetic model.
module tb_fp32_mult;

    logic        clk;
    logic        rst_n;
    logic [31:0] A, B;
    logic [31:0] result;
    logic        overflow, underflow;

    int n_vec = 0;
    int n_bad = 0;

    fp32_mult dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .result   (result),
        .overflow (overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got {ov,un,res}=%h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact integer product, normalized and rounded by remainder comparison
    function automatic logic [33:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic              sign;
        int                ea, eb, s, e;
        longint unsigned   fa, fb, p, q, rem, half;
        logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        sign   = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        fa     = longint'(a[22:0]);
        fb     = longint'(b[22:0]);
        a_nan  = (ea == 255) && (fa != 0);
        b_nan  = (eb == 255) && (fb != 0);
        a_inf  = (ea == 255) && (fa == 0);
        b_inf  = (eb == 255) && (fb == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan) return {2'b00, 32'h7FC00000};
        if ((a_inf && b_zero) || (b_inf && a_zero)) return {2'b00, 32'h7FC00000};
        if (a_inf || b_inf) return {2'b00, sign, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {2'b00, sign, 31'd0};
        p = ((64'd1 << 23) + fa) * ((64'd1 << 23) + fb);
        s = 0;
        while ((p >> s) >= (64'd1 << 24)) s++;
        q    = p >> s;
        rem  = p - (q << s);
        half = 64'd1 << (s - 1);
        if ((rem > half) || ((rem == half) && q[0])) q++;
        e = s + ea + eb - 150;
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            e++;
        end
        if (e >= 255) return {2'b10, sign, 8'hFF, 23'd0};
        if (e <= 0)   return {2'b01, sign, 31'd0};
        return {2'b00, sign, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [7:0]  e;
        logic [31:0] f;
        int          k;
        k = $urandom_range(0, 11);
        case (k)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'($urandom_range(1, 254));
            3:       e = 8'($urandom_range(190, 254));
            4:       e = 8'($urandom_range(1, 64));
            default: e = 8'($urandom_range(70, 185));
        endcase
        f = $urandom;
        if ($urandom_range(0, 7) == 0) f = 32'd0;
        return {1'($urandom_range(0, 1)), e, f[22:0]};
    endfunction

    task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [33:0] exp);
        @(negedge clk);
        A = a;
        B = b;
        @(posedge clk);
        #1;
        check_vec(tag, {overflow, underflow, result}, exp);
    endtask

    initial begin
        logic [31:0] ra, rb;
        rst_n = 1'b0;
        A     = 32'h3F800000;
        B     = 32'h40000000;
        #1;
        check_vec("reset_state", {overflow, underflow, result}, 34'd0);
        @(posedge clk);
        #1;
        check_vec("reset_hold", {overflow, underflow, result}, 34'd0);
        @(negedge clk);
        rst_n = 1'b1;

        apply("2x1",        32'h40000000, 32'h3F800000, {2'b00, 32'h40000000});
        apply("2x2",        32'h40000000, 32'h40000000, {2'b00, 32'h40800000});
        apply("5.25x2",     32'h40A80000, 32'h40000000, {2'b00, 32'h41280000});
        apply("neg1x2",     32'hBF800000, 32'h40000000, {2'b00, 32'hC0000000});
        apply("2.5x3.5",    32'h40200000, 32'h40600000, {2'b00, 32'h410C0000});
        apply("neg_round",  32'h44FC7333, 32'hC0600000, ref_mul(32'h44FC7333, 32'hC0600000));
        apply("nan_op",     32'h44FC7333, 32'hFF800001, {2'b00, 32'h7FC00000});
        apply("zero_zero",  32'h00000000, 32'h00000000, {2'b00, 32'h00000000});
        apply("ninf_pinf",  32'hFF800000, 32'h7F800000, {2'b00, 32'hFF800000});
        apply("inf_zero",   32'h7F800000, 32'h00000000, {2'b00, 32'h7FC00000});
        apply("ninf_ninf",  32'hFF800000, 32'hFF800000, {2'b00, 32'h7F800000});
        apply("subn_flush", 32'h00400000, 32'hC0000000, {2'b00, 32'h80000000});
        apply("underflow",  32'h00800000, 32'h3F000000, {2'b01, 32'h00000000});
        apply("round_sticky", 32'h3F800001, 32'h3F800001, {2'b00, 32'h3F800002});
        apply("round_carry",  32'h3F800001, 32'h3FFFFFFE, {2'b00, 32'h40000000});

        // Inputs changing between edges must not disturb the held outputs
        #2;
        A = 32'h40000000;
        B = 32'h40400000;
        #2;
        check_vec("hold_between_edges", {overflow, underflow, result}, {2'b00, 32'h40000000});

        apply("overflow",   32'h7F000000, 32'h40000000, {2'b10, 32'h7F800000});
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("async_reset", {overflow, underflow, result}, 34'd0);
        A = 32'h40000000;
        B = 32'h40000000;
        @(posedge clk);
        #1;
        check_vec("edge_in_reset", {overflow, underflow, result}, 34'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_vec("pre_first_edge", {overflow, underflow, result}, 34'd0);
        @(posedge clk);
        #1;
        check_vec("first_after_reset", {overflow, underflow, result}, {2'b00, 32'h40800000});

        for (int i = 0; i < 500; i++) begin
            ra = rnd_op();
            rb = rnd_op();
            apply("random", ra, rb, ref_mul(ra, rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
